// File: rtl/fifo_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb_pkg
// Shared types and helpers for the fifo_wr_arbiter slice.
//   arb_state_e : arbiter FSM encoding (IDLE, GRANT)
//   STAT_W      : width of the optional statistics counters
//   STAT_SAT    : saturation value of the statistics counters
//   next_rr()   : cyclic priority search over a padded valid vector
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_SAT = 16'hFFFF;

  // Search is always done over the largest legal requester count; unused
  // upper lanes are zero, which makes a 16-way wrap equivalent to a
  // NUM_REQ-way wrap for any start index below NUM_REQ.
  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  // Burst counter width, large enough for MAX_BURST up to 255.
  localparam int BURST_W = 8;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_result_t;

  // First set bit of valid_vec found walking upward from start_idx with wrap.
  function automatic rr_result_t next_rr(input logic [MAX_REQ-1:0]   valid_vec,
                                         input logic [MAX_IDX_W-1:0] start_idx);
    rr_result_t           res;
    logic [MAX_IDX_W-1:0] pos;
    res.found = 1'b0;
    res.idx   = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      pos = start_idx + MAX_IDX_W'(i);
      if (!res.found && valid_vec[pos]) begin
        res.found = 1'b1;
        res.idx   = pos;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the producer streams, the fifo_sync write port and the status
// outputs of fifo_wr_arbiter.
//   i_req_valid / i_req_data / o_req_ready : NUM_REQ producer streams
//   o_grant     : one-hot registered grant
//   o_fifo_wr / o_fifo_data / i_fifo_full  : fifo_sync write side
//   o_busy      : a grant is active
//   o_beat_cnt / o_stall_cnt : statistics, only with FIFO_WR_ARB_STATS_EN
// Modports:
//   slave  : the arbiter itself
//   master : the environment (producers and the FIFO) facing the arbiter
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if
  import fifo_wr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);

  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            o_grant;
  logic                          o_fifo_wr;
  logic [DATA_WIDTH-1:0]         o_fifo_data;
  logic                          i_fifo_full;
  logic                          o_busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*STAT_W-1:0]     o_beat_cnt;
  logic [STAT_W-1:0]             o_stall_cnt;
`endif

  modport slave (
    input  i_req_valid,
    input  i_req_data,
    input  i_fifo_full,
    output o_req_ready,
    output o_grant,
    output o_fifo_wr,
    output o_fifo_data,
`ifdef FIFO_WR_ARB_STATS_EN
    output o_beat_cnt,
    output o_stall_cnt,
`endif
    output o_busy
  );

  modport master (
    output i_req_valid,
    output i_req_data,
    output i_fifo_full,
    input  o_req_ready,
    input  o_grant,
    input  o_fifo_wr,
    input  o_fifo_data,
`ifdef FIFO_WR_ARB_STATS_EN
    input  o_beat_cnt,
    input  o_stall_cnt,
`endif
    input  o_busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational cyclic priority search: returns the first set bit of i_valid
// at or after i_start, wrapping modulo NUM_REQ.
//   i_valid  [NUM_REQ]   candidate vector
//   i_start  [REQ_IDX_W] index searched first
//   o_found              any candidate present
//   o_onehot [NUM_REQ]   one-hot of the winner (zero when none)
//   o_idx    [REQ_IDX_W] binary index of the winner
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   i_valid,
  input  logic [REQ_IDX_W-1:0] i_start,
  output logic                 o_found,
  output logic [NUM_REQ-1:0]   o_onehot,
  output logic [REQ_IDX_W-1:0] o_idx
);

  logic [MAX_REQ-1:0]   valid_pad_s;
  logic [MAX_IDX_W-1:0] start_pad_s;
  rr_result_t           pick_s;

  // Zero-pad to the package search width and run the search.
  always_comb begin
    valid_pad_s                = '0;
    valid_pad_s[NUM_REQ-1:0]   = i_valid;
    start_pad_s                = '0;
    start_pad_s[REQ_IDX_W-1:0] = i_start;
    pick_s                     = next_rr(valid_pad_s, start_pad_s);
  end

  // Decode the winning index to one-hot.
  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_onehot[k] = pick_s.found && (pick_s.idx == MAX_IDX_W'(k));
    end
  end

  assign o_found = pick_s.found;
  assign o_idx   = pick_s.idx[REQ_IDX_W-1:0];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one fifo_sync write port between NUM_REQ
// valid/ready producers. A grant is held for at most MAX_BURST accepted beats
// and every write is gated by the FIFO full flag.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : fifo_wr_arbiter_if.slave (producer streams, FIFO write port,
//            grant, busy, optional statistics)
// Parameters: DATA_WIDTH, NUM_REQ (2..16), MAX_BURST (1..255).
// Optional feature macro: FIFO_WR_ARB_STATS_EN adds per-requester saturating
// beat counters (o_beat_cnt) and a full-stall counter (o_stall_cnt).
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int REQ_IDX_W = $clog2(NUM_REQ);
  localparam logic [REQ_IDX_W-1:0] LAST_IDX   = REQ_IDX_W'(NUM_REQ - 1);
  localparam logic [BURST_W-1:0]   BURST_LAST = BURST_W'(MAX_BURST - 1);

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_GRANT = GRANT;

  logic [0:0]            state_r;
  logic [NUM_REQ-1:0]    grant_r;
  logic [REQ_IDX_W-1:0]  gidx_r;
  logic [REQ_IDX_W-1:0]  last_r;
  logic [BURST_W-1:0]    cnt_r;

  logic                  in_grant_s;
  logic                  g_valid_s;
  logic                  beat_s;
  logic                  last_beat_s;
  logic                  release_s;
  logic [REQ_IDX_W-1:0]  base_idx_s;
  logic [REQ_IDX_W-1:0]  start_idx_s;
  logic [NUM_REQ-1:0]    pick_vec_s;
  logic                  found_s;
  logic [NUM_REQ-1:0]    pick_onehot_s;
  logic [REQ_IDX_W-1:0]  pick_idx_s;
  logic [DATA_WIDTH-1:0] data_sel_s;

  // Handshake and release decode for the current grantee.
  always_comb begin
    // Reset gating makes an in-flight beat vanish the moment reset asserts.
    in_grant_s  = (state_r == ST_GRANT) && !i_rst;
    g_valid_s   = |(bus.i_req_valid & grant_r);
    beat_s      = in_grant_s && g_valid_s && !bus.i_fifo_full;
    last_beat_s = beat_s && (cnt_r == BURST_LAST);
    release_s   = in_grant_s && (last_beat_s || !g_valid_s);
  end

  // Search origin and candidate set. A forced hand-off masks the grantee so
  // it waits behind everyone else; a valid-drop already excludes it.
  always_comb begin
    if (in_grant_s) begin
      base_idx_s = gidx_r;
    end else begin
      base_idx_s = last_r;
    end
    if (base_idx_s == LAST_IDX) begin
      start_idx_s = '0;
    end else begin
      start_idx_s = base_idx_s + REQ_IDX_W'(1);
    end
    if (last_beat_s) begin
      pick_vec_s = bus.i_req_valid & ~grant_r;
    end else begin
      pick_vec_s = bus.i_req_valid;
    end
  end

  rr_pick #(
    .NUM_REQ   (NUM_REQ),
    .REQ_IDX_W (REQ_IDX_W)
  ) u_pick (
    .i_valid  (pick_vec_s),
    .i_start  (start_idx_s),
    .o_found  (found_s),
    .o_onehot (pick_onehot_s),
    .o_idx    (pick_idx_s)
  );

  // Arbitration state, grant register, hand-off pointer and burst counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      gidx_r  <= '0;
      last_r  <= LAST_IDX;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            state_r <= ST_GRANT;
            grant_r <= pick_onehot_s;
            gidx_r  <= pick_idx_s;
            cnt_r   <= '0;
          end else begin
            state_r <= ST_IDLE;
            grant_r <= '0;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            last_r <= gidx_r;
            cnt_r  <= '0;
            if (found_s) begin
              // Back-to-back hand-off, no idle bubble.
              state_r <= ST_GRANT;
              grant_r <= pick_onehot_s;
              gidx_r  <= pick_idx_s;
            end else begin
              state_r <= ST_IDLE;
              grant_r <= '0;
            end
          end else if (beat_s) begin
            cnt_r <= cnt_r + BURST_W'(1);
          end else begin
            // Full stall or waiting: grant and count held.
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= '0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Data of the granted requester, selected by the one-hot grant.
  always_comb begin
    data_sel_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      data_sel_s = data_sel_s |
                   (grant_r[k] ? bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH]
                               : {DATA_WIDTH{1'b0}});
    end
  end

  // Port drive: ready, strobe and data follow the registered grant directly
  // so the FIFO write lands in the same cycle as the producer handshake.
  always_comb begin
    if (in_grant_s && !bus.i_fifo_full) begin
      bus.o_req_ready = grant_r;
    end else begin
      bus.o_req_ready = '0;
    end
    if (in_grant_s) begin
      bus.o_fifo_data = data_sel_s;
    end else begin
      bus.o_fifo_data = '0;
    end
    bus.o_fifo_wr = beat_s;
  end

  assign bus.o_grant = grant_r;
  assign bus.o_busy  = in_grant_s;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*STAT_W-1:0] beat_cnt_r;
  logic [STAT_W-1:0]         stall_cnt_r;
  logic                      stall_s;

  assign stall_s = in_grant_s && g_valid_s && bus.i_fifo_full;

  // Saturating per-requester accepted-beat counters and full-stall counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_cnt_r  <= '0;
      stall_cnt_r <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (beat_s && grant_r[k] && (beat_cnt_r[k*STAT_W +: STAT_W] != STAT_SAT)) begin
          beat_cnt_r[k*STAT_W +: STAT_W] <= beat_cnt_r[k*STAT_W +: STAT_W] + STAT_W'(1);
        end else begin
          beat_cnt_r[k*STAT_W +: STAT_W] <= beat_cnt_r[k*STAT_W +: STAT_W];
        end
      end
      if (stall_s && (stall_cnt_r != STAT_SAT)) begin
        stall_cnt_r <= stall_cnt_r + STAT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign bus.o_beat_cnt  = beat_cnt_r;
  assign bus.o_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one fifo_sync write port between NUM_REQ producers. Each producer presents a valid/ready stream. The arbiter grants one producer at a time, holds the grant for a bounded burst, and gates every write with the FIFO full flag so the FIFO never records an overrun. It sits between the producer blocks and the fifo_sync i_wr/i_data inputs.

Parameters:
- DATA_WIDTH, 8: width of each requester's data and of the FIFO write data.
- NUM_REQ, 4: number of requesters, 2..16.
- MAX_BURST, 4: maximum accepted beats per grant before forced hand-off, 1..255.
- REQ_IDX_W, $clog2(NUM_REQ): width of the grant index (localparam).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester data valid.
- i_req_data  in  NUM_REQ*DATA_WIDTH  requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_req_ready  out  NUM_REQ  per-requester accept; a beat transfers when valid&&ready.
- o_grant  out  NUM_REQ  one-hot registered grant, all zero when idle.
- o_fifo_wr  out  1  write strobe to fifo_sync i_wr.
- o_fifo_data  out  DATA_WIDTH  write data to fifo_sync i_data.
- i_fifo_full  in  1  fifo_sync full flag (o_status[1]).
- o_busy  out  1  a grant is active (state == GRANT).

Behaviour:
- Reset (async, i_rst=1): state=IDLE, o_grant=0, burst count=0, last-grant pointer=NUM_REQ-1 so that the first search starts at requester 0. While in reset, o_req_ready=0, o_fifo_wr=0, o_fifo_data=0, o_busy=0. Reset mid-burst aborts the grant immediately. No beat is accepted in the cycle reset asserts.
- States: IDLE and GRANT.
- IDLE:
  - If any i_req_valid is set, select the first valid index searching cyclically from last+1.
  - Register the one-hot grant and go to GRANT next cycle, so arbitration latency is 1 cycle.
  - If no requester is valid, stay in IDLE.
- GRANT, requester g:
  - o_req_ready[g] = !i_fifo_full. All other ready bits are 0.
  - Beat = i_req_valid[g] && o_req_ready[g].
  - o_fifo_wr = beat. o_fifo_data = data of g. Both are combinational from the registered grant, with zero added latency, so the write lands in the FIFO the same cycle as the handshake.
  - On each beat, burst count increments.
  - When i_fifo_full=1: no beat, grant is held, count unchanged, no timeout.
- Release condition: a beat with count==MAX_BURST-1, or i_req_valid[g]==0 in any GRANT cycle.
  - On release: last=g, count=0.
  - Re-arbitrate in the same cycle, searching from g+1 and excluding g only in the forced-MAX_BURST case. The valid-drop case naturally excludes g.
  - If another requester is valid, the new grant is loaded on the next edge with no idle bubble; otherwise go to IDLE.
  - A released requester that is still valid is granted again only after every other valid requester has been served, or immediately if it is the only valid requester.
- Valid-drop release applies only when the grantee drops valid; a beat with count below MAX_BURST-1 does not release.
- Fairness: worst-case wait for a continuously valid requester is (NUM_REQ-1)*MAX_BURST beats plus full-stall cycles.
- Pointer arithmetic wraps modulo NUM_REQ; the index is REQ_IDX_W bits.
- Producers must hold valid and data stable until ready. The arbiter does not check this.
- The fifo_sync full flag asserts at fill==depth-1, so the arbiter never writes the last slot. This is accepted; the arbiter never issues a write while full is asserted.

Optional Feature:
- Macro FIFO_WR_ARB_STATS_EN.
- Defined: adds output o_beat_cnt, width NUM_REQ*16, with one 16-bit saturating accepted-beat counter per requester. Counters clear on i_rst and hold at 16'hFFFF when saturated. Also adds output o_stall_cnt, 16 bits, a saturating count of GRANT cycles where i_req_valid[g]=1 and i_fifo_full=1.
- Undefined: those ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Package fifo_wr_arb_pkg:
  - state enum {IDLE, GRANT}.
  - STAT_W=16 and the saturate value.
  - A function next_rr(valid_vec, start_idx) returning the found flag and index.
- One sub-module, rr_pick: combinational cyclic priority search (valid vector plus start index, giving one-hot and index). It is reused for IDLE and hand-off arbitration.

Test Plan:
- Reset, then i_req_valid=4'b0001 with 3 beats, full=0 -> grant 0001 on cycle 1, o_fifo_wr high 3 cycles carrying data in order, then IDLE with o_busy=0.
- All 4 valid continuously, MAX_BURST=4, full=0 -> grant order 0,1,2,3,0 with exactly 4 writes each and no bubble cycles between grants.
- Requester 2 granted, i_fifo_full=1 for 5 cycles mid-burst -> o_req_ready[2]=0, o_fifo_wr=0, count frozen. When full drops, the burst resumes and totals 4 beats.
- Requester 1 drops valid after 2 beats while 3 is valid -> next cycle grant=1000, last=1, and requester 3 completes its burst.
- Assert i_rst asynchronously mid-burst -> o_grant=0 and o_fifo_wr=0 immediately. After release with all valid, the first grant goes to requester 0.
- With FIFO_WR_ARB_STATS_EN, 70000 beats from requester 0 -> o_beat_cnt[15:0]=16'hFFFF, and the other counters remain 0.
